// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM state encodings shared by seq_alu
// Purpose : common definitions for the sequential ALU.
// Contents: OP_ADD..OP_DIVU op-code values, state_t FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative unsigned multiply / restoring divide datapath
// Purpose : one result bit per cycle; WIDTH iterations after i_start.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_start   load operands and begin (ignored fields when not set)
//           i_is_div  1 = divide, 0 = multiply
//           i_a, i_b  operands (a = multiplicand/dividend, b = multiplier/divisor)
//           o_busy    iterating
//           o_last    final iteration happens on the coming clock edge
//           o_hi/o_lo MUL {hi,lo}=a*b ; DIV lo=quotient, hi=remainder
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_is_div;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH+1:0] w_div_trial;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_last;

  // Multiply: {hi,lo} holds partial product and the unconsumed multiplier bits.
  // Add b when the current multiplier LSB is set, then shift the pair right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide: shift the next dividend bit into the remainder and try to subtract.
  // Two guard bits: the shifted remainder can reach 2^WIDTH when b==0, and the
  // top bit is the borrow. With b==0 the subtraction never borrows, which
  // yields an all-ones quotient and leaves the dividend in hi.
  assign w_div_trial = {1'b0, r_hi, r_lo[WIDTH-1]} - {2'b00, r_b};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_is_div) begin
      if (!w_div_trial[WIDTH+1]) begin
        w_hi_nxt = w_div_trial[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_last = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_hi     <= '0;
      r_lo     <= i_a;
      r_b      <= i_b;
      r_is_div <= i_is_div;
      r_busy   <= 1'b1;
      r_cnt    <= '0;
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_last = w_last;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked execute-stage ALU with iterative MULU/DIVU
// Purpose : single-cycle add/sub/logic/shift/compare plus WIDTH-cycle mul/div,
//           registered result held until the consumer takes it.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_in_valid / o_in_ready   request handshake (o_in_ready = IDLE)
//           i_op, i_a, i_b            request, captured at accept
//           o_out_valid / i_out_ready result handshake
//           o_res_lo  result / MUL low word / DIV quotient
//           o_res_hi  MUL high word / DIV remainder, 0 otherwise
//           o_err     illegal op code (11..15)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_res_lo,
  output logic [WIDTH-1:0] o_res_hi,
  output logic             o_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_err;
  logic             r_use_mdu;

  logic             w_accept;
  logic             w_is_mdu;
  logic             w_illegal;
  logic [WIDTH-1:0] w_alu_lo;
  logic [SHAMT_W-1:0] w_shamt;

  logic             w_mdu_busy;
  logic             w_mdu_last;
  logic [WIDTH-1:0] w_mdu_hi;
  logic [WIDTH-1:0] w_mdu_lo;

  assign w_accept  = i_in_valid && (r_state == ST_IDLE);
  assign w_is_mdu  = (i_op == OP_MULU) || (i_op == OP_DIVU);
  assign w_illegal = (i_op > OP_DIVU);
  assign w_shamt   = i_b[SHAMT_W-1:0];

  // Single-cycle results are computed from the request at accept and
  // registered, which is equivalent to capturing op/a/b.
  always_comb begin
    w_alu_lo = '0;
    case (i_op)
      OP_ADD:  w_alu_lo = i_a + i_b;
      OP_SUB:  w_alu_lo = i_a - i_b;
      OP_AND:  w_alu_lo = i_a & i_b;
      OP_OR:   w_alu_lo = i_a | i_b;
      OP_SRL:  w_alu_lo = i_a >> w_shamt;
      OP_SRA:  w_alu_lo = $unsigned($signed(i_a) >>> w_shamt);
      OP_SLL:  w_alu_lo = i_a << w_shamt;
      OP_SLT:  w_alu_lo = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_alu_lo = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default: w_alu_lo = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_accept && w_is_mdu),
    .i_is_div (i_op == OP_DIVU),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (w_mdu_busy),
    .o_last   (w_mdu_last),
    .o_hi     (w_mdu_hi),
    .o_lo     (w_mdu_lo)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // BUSY leaves on the edge that performs the last iteration, so the result
  // is present the first cycle of DONE: WIDTH+1 edges from accept to valid.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_is_mdu ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_mdu_last || !w_mdu_busy) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_lo  <= '0;
      r_err     <= 1'b0;
      r_use_mdu <= 1'b0;
    end else if (w_accept) begin
      r_res_lo  <= w_alu_lo;
      r_err     <= w_illegal;
      r_use_mdu <= w_is_mdu;
    end
  end

  // The mdu holds its registers once idle, so steering its outputs directly
  // keeps the result stable through DONE.
  assign o_res_lo = r_use_mdu ? w_mdu_lo : r_res_lo;
  assign o_res_hi = r_use_mdu ? w_mdu_hi : '0;
  assign o_err    = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized self-checking bench for seq_alu
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        err;

  int checks;
  int errors;

  seq_alu #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_res_lo    (res_lo),
    .o_res_hi    (res_hi),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: arithmetic straight from the op definitions.
  task automatic model(input logic [3:0] m_op, input logic [31:0] m_a, input logic [31:0] m_b,
                       output logic [31:0] m_lo, output logic [31:0] m_hi,
                       output logic m_err, output int m_lat);
    logic [63:0] prod;
    int sh;
    sh    = int'(m_b % 32);
    m_lo  = 0;
    m_hi  = 0;
    m_err = 0;
    m_lat = 1;
    case (m_op)
      4'd0: m_lo = m_a + m_b;
      4'd1: m_lo = m_a - m_b;
      4'd2: m_lo = m_a & m_b;
      4'd3: m_lo = m_a | m_b;
      4'd4: m_lo = m_a / (32'd1 << sh);
      4'd5: m_lo = 32'($signed(m_a) >>> sh);
      4'd6: m_lo = m_a * (32'd1 << sh);
      4'd7: m_lo = (int'(m_a) < int'(m_b)) ? 1 : 0;
      4'd8: m_lo = (m_a < m_b) ? 1 : 0;
      4'd9: begin
        prod  = 64'(m_a) * 64'(m_b);
        m_lo  = prod[31:0];
        m_hi  = prod[63:32];
        m_lat = 33;
      end
      4'd10: begin
        if (m_b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = m_a;
        end else begin
          m_lo = m_a / m_b;
          m_hi = m_a % m_b;
        end
        m_lat = 33;
      end
      default: m_err = 1;
    endcase
  endtask

  // Drives one request and collects the result; leaves out_ready low.
  task automatic run_op(input logic [3:0] r_op, input logic [31:0] r_a, input logic [31:0] r_b,
                        output int lat, output logic [31:0] lo, output logic [31:0] hi,
                        output logic er, output bit rdy_low, output bit tmo);
    int n;
    tmo = 0; rdy_low = 1; lat = 0; lo = 0; hi = 0; er = 0;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tmo = 1;
      return;
    end
    in_valid = 1; op = r_op; a = r_a; b = r_b;
    @(posedge clk);
    #1;
    in_valid = 0; op = 4'($urandom); a = $urandom; b = $urandom;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) rdy_low = 0;
    end while (!out_valid && lat < 100);
    if (!out_valid) begin
      tmo = 1;
      return;
    end
    lo = res_lo; hi = res_hi; er = err;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask

  task automatic check_op(input string name, input logic [3:0] t_op,
                          input logic [31:0] t_a, input logic [31:0] t_b);
    int lat, m_lat;
    logic [31:0] lo, hi, m_lo, m_hi;
    logic er, m_err;
    bit rl, tmo;
    model(t_op, t_a, t_b, m_lo, m_hi, m_err, m_lat);
    run_op(t_op, t_a, t_b, lat, lo, hi, er, rl, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL %s timeout op=%0d a=%h b=%h", name, t_op, t_a, t_b);
      return;
    end
    checks++;
    if (lo !== m_lo) begin
      errors++;
      $display("FAIL %s res_lo op=%0d a=%h b=%h got %h want %h", name, t_op, t_a, t_b, lo, m_lo);
    end
    checks++;
    if (hi !== m_hi) begin
      errors++;
      $display("FAIL %s res_hi op=%0d a=%h b=%h got %h want %h", name, t_op, t_a, t_b, hi, m_hi);
    end
    checks++;
    if (er !== m_err) begin
      errors++;
      $display("FAIL %s err op=%0d got %b want %b", name, t_op, er, m_err);
    end
    checks++;
    if (lat !== m_lat) begin
      errors++;
      $display("FAIL %s latency op=%0d got %0d want %0d", name, t_op, lat, m_lat);
    end
    checks++;
    if (!rl) begin
      errors++;
      $display("FAIL %s in_ready high while busy op=%0d got 1 want 0", name, t_op);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res_lo !== 0 || res_hi !== 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b lo=%h hi=%h err=%b want 1 0 0 0 0",
               in_ready, out_valid, res_lo, res_hi, err);
    end
  endtask

  task automatic test_directed();
    check_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    check_op("sra",      4'd5, 32'h8000_0000, 32'd36);
    check_op("srl",      4'd4, 32'h8000_0000, 32'd36);
    check_op("slt",      4'd7, 32'hFFFF_FFFF, 32'd1);
    check_op("sltu",     4'd8, 32'hFFFF_FFFF, 32'd1);
    check_op("mulu_max", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("divu",     4'd10, 32'd100, 32'd7);
    check_op("divu_by0", 4'd10, 32'd1234, 32'd0);
    check_op("illegal",  4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
  endtask

  // Spot checks of the literal expected values, independent of the model.
  task automatic test_spec_values();
    int lat;
    logic [31:0] lo, hi;
    logic er;
    bit rl, tmo;
    run_op(4'd5, 32'h8000_0000, 32'd36, lat, lo, hi, er, rl, tmo);
    checks++;
    if (lo !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra_literal got %h want F8000000", lo);
    end
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, lo, hi, er, rl, tmo);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || lat !== 33) begin
      errors++;
      $display("FAIL mulu_literal got hi=%h lo=%h lat=%0d want FFFFFFFE 00000001 33", hi, lo, lat);
    end
    run_op(4'd10, 32'd100, 32'd7, lat, lo, hi, er, rl, tmo);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL divu_literal got lo=%0d hi=%0d want 14 2", lo, hi);
    end
  endtask

  task automatic test_random();
    logic [3:0] r_op;
    logic [31:0] r_a, r_b;
    for (int i = 0; i < 120; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 5))
        0: r_b = 0;
        1: r_b = $urandom_range(1, 40);
        2: r_a = 32'hFFFF_FFFF;
        default: ;
      endcase
      check_op("random", r_op, r_a, r_b);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lo0, hi0;
    logic er0;
    bit stable;
    int n;
    @(negedge clk);
    in_valid = 1; op = 4'd10; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    // Keep a different request asserted: it must be ignored until IDLE.
    op = 4'd0; a = 32'd5; b = 32'd6;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_timeout got out_valid=0 want 1");
      in_valid = 0;
      return;
    end
    lo0 = res_lo; hi0 = res_hi; er0 = err;
    stable = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_lo !== lo0 || res_hi !== hi0 || err !== er0)
        stable = 0;
    end
    checks++;
    if (!stable || lo0 !== 32'd14 || hi0 !== 32'd2) begin
      errors++;
      $display("FAIL bp_stable got lo=%0d hi=%0d stable=%0d want 14 2 1", res_lo, res_hi, stable);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_return got %b want 1", in_ready);
    end
    // Held ADD request is accepted now.
    @(posedge clk);
    #1;
    in_valid = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || res_lo !== 32'd11 || res_hi !== 0) begin
      errors++;
      $display("FAIL bp_held_req got vld=%b lo=%0d want 1 11", out_valid, res_lo);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] lo, hi;
    logic er;
    bit rl, tmo;
    run_op(4'd15, 32'hDEAD_BEEF, 32'h1, lat, lo, hi, er, rl, tmo);
    checks++;
    if (tmo || er !== 1'b1 || lo !== 0 || hi !== 0) begin
      errors++;
      $display("FAIL illegal_f got err=%b lo=%h hi=%h tmo=%0d want 1 0 0 0", er, lo, hi, tmo);
    end
    // No same-cycle re-accept: in_ready low in the handshake cycle, high next.
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b want 1", in_ready);
    end
    check_op("b2b_sub", 4'd1, 32'd3, 32'd5);
  endtask

  task automatic test_reset_mid_op();
    bit clean;
    @(negedge clk);
    in_valid = 1; op = 4'd9; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    clean = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_lo !== 0 || res_hi !== 0) clean = 0;
    end
    checks++;
    if (!clean) begin
      errors++;
      $display("FAIL stale_after_reset got vld=%b lo=%h want 0 0", out_valid, res_lo);
    end
    check_op("after_reset", 4'd9, 32'd12345, 32'd678);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 0; in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    test_reset();
    test_directed();
    test_spec_values();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
